// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory-port dump sniffer.
// Signature addresses, record layout and end-of-run causes.
package mem_dump_pkg;

  localparam int ADDR_STOP_SIG           = 0;
  localparam int ADDR_IREG_DUMP_SIG      = 1;
  localparam int ADDR_REGSTREAM_DUMP_SIG = 2;

  localparam int  DUMP_ID_W   = 8;
  localparam logic KIND_IREG   = 1'b0;
  localparam logic KIND_STREAM = 1'b1;

  typedef struct packed {
    logic                 kind;
    logic [DUMP_ID_W-1:0] id;
    logic [63:0]          value;
    logic [63:0]          value_t0;
  } dump_rec_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_STOP   = 2'd1,
    CAUSE_SIMLEN = 2'd2
  } done_cause_e;

endpackage

// File: rtl/dump_rec_fifo.sv
// First-word-fall-through record FIFO; a push into a full FIFO is
// accepted when a pop happens at the same edge.
module dump_rec_fifo
  import mem_dump_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type rec_t = dump_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t wr_data,
  input  logic pop,
  output rec_t rd_data,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  rec_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_dump_sniffer.sv
// Observer on the SoC memory port: queues ireg/regstream dump records
// and raises the end-of-run indication (stop drain or cycle limit).
module mem_dump_sniffer
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_DRAIN = 50,
  parameter int ID_W       = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [DATA_W-1:0] mem_wdata_t0_i,
  input  logic [31:0]       simlen_i,
  output logic              rec_valid_o,
  input  logic              rec_ready_i,
  output logic              rec_kind_o,
  output logic [ID_W-1:0]   rec_id_o,
  output logic [63:0]       rec_value_o,
  output logic [63:0]       rec_value_t0_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic [1:0]        done_cause_o
);

  typedef struct packed {
    logic            kind;
    logic [ID_W-1:0] id;
    logic [63:0]     value;
    logic [63:0]     value_t0;
  } rec_t;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam int DRN_W = (STOP_DRAIN < 1) ? 1 : $clog2(STOP_DRAIN + 1);

  logic [1:0]       state;
  logic [DRN_W-1:0] drain_cnt;
  logic [31:0]      step;
  logic [ID_W-1:0]  ireg_id, strm_id;
  done_cause_e      cause;
  logic             overflow;

  logic beat, is_stop, is_ireg, is_strm, push, pop, simlen_hit;
  logic fifo_empty, fifo_full;
  rec_t wr_rec, rd_rec;

  // Only the low 64 bits of data/taint are recorded.
  logic unused_hi;
  assign unused_hi = ^{mem_wdata_i[DATA_W-1:64], mem_wdata_t0_i[DATA_W-1:64]};

  assign beat    = mem_req_i & mem_we_i & (state == ST_RUN);
  assign is_stop = beat & (mem_addr_i == ADDR_W'(ADDR_STOP_SIG));
  assign is_ireg = beat & (mem_addr_i == ADDR_W'(ADDR_IREG_DUMP_SIG));
  assign is_strm = beat & (mem_addr_i == ADDR_W'(ADDR_REGSTREAM_DUMP_SIG));
  assign push    = is_ireg | is_strm;
  assign pop     = rec_valid_o & rec_ready_i;

  assign simlen_hit = (state != ST_DONE) && (simlen_i != 32'd0) &&
                      (step == simlen_i - 32'd1);

  always_comb begin
    wr_rec          = '0;
    wr_rec.kind     = is_strm ? KIND_STREAM : KIND_IREG;
    wr_rec.id       = is_strm ? strm_id : ireg_id;
    wr_rec.value    = mem_wdata_i[63:0];
    wr_rec.value_t0 = mem_wdata_t0_i[63:0];
  end

  dump_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (push),
    .wr_data (wr_rec),
    .pop     (pop),
    .rd_data (rd_rec),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      step      <= '0;
      ireg_id   <= ID_W'(1);
      strm_id   <= '0;
      cause     <= CAUSE_NONE;
      overflow  <= 1'b0;
    end else begin
      // Ids advance even when the record is dropped so gaps show downstream.
      if (is_ireg) ireg_id <= ireg_id + ID_W'(1);
      if (is_strm) strm_id <= strm_id + ID_W'(1);
      if (push & fifo_full & ~pop) overflow <= 1'b1;
      if (state != ST_DONE) step <= step + 32'd1;

      if (simlen_hit) begin
        state <= ST_DONE;
        cause <= CAUSE_SIMLEN;
      end else if (is_stop) begin
        state     <= ST_DRAIN;
        drain_cnt <= DRN_W'(STOP_DRAIN);
      end else if (state == ST_DRAIN) begin
        if (drain_cnt == '0) begin
          state <= ST_DONE;
          cause <= CAUSE_STOP;
        end else begin
          drain_cnt <= drain_cnt - DRN_W'(1);
        end
      end
    end
  end

  assign rec_valid_o    = ~fifo_empty;
  assign rec_kind_o     = rec_valid_o & rd_rec.kind;
  assign rec_id_o       = rec_valid_o ? rd_rec.id : '0;
  assign rec_value_o    = rec_valid_o ? rd_rec.value : '0;
  assign rec_value_t0_o = rec_valid_o ? rd_rec.value_t0 : '0;
  assign overflow_o     = overflow;
  assign done_o         = (state == ST_DONE);
  assign done_cause_o   = cause;

endmodule

// File: tb/tb_mem_dump_sniffer.sv
// Directed plus randomized bench for mem_dump_sniffer, checked against an
// edge-numbered reference model with a record queue.
module tb_mem_dump_sniffer;

  localparam int SD    = 3;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         mem_req = 1'b0, mem_we = 1'b0;
  logic [20:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0, mem_wdata_t0 = '0;
  logic [31:0]  simlen = '0;
  logic         rec_ready = 1'b0;
  logic         rec_valid, rec_kind, overflow, done;
  logic [7:0]   rec_id;
  logic [63:0]  rec_value, rec_value_t0;
  logic [1:0]   done_cause;

  mem_dump_sniffer #(
    .ADDR_W(21), .DATA_W(128), .FIFO_DEPTH(DEPTH), .STOP_DRAIN(SD), .ID_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .mem_req_i(mem_req), .mem_we_i(mem_we),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_wdata_t0_i(mem_wdata_t0),
    .simlen_i(simlen), .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
    .rec_kind_o(rec_kind), .rec_id_o(rec_id), .rec_value_o(rec_value),
    .rec_value_t0_o(rec_value_t0), .overflow_o(overflow), .done_o(done),
    .done_cause_o(done_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          kind;
    int          id;
    logic [63:0] value;
    logic [63:0] t0;
  } mrec_t;

  // Reference model: edges numbered from 1 after reset.
  mrec_t m_q[$];
  int    edge_n, stop_edge, m_cause, m_ireg, m_strm;
  bit    m_done, m_ovf;
  int    checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_n = 0; stop_edge = -1; m_cause = 0; m_done = 0; m_ovf = 0;
    m_ireg = 1; m_strm = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit wr, input logic [20:0] addr,
                            input logic [63:0] d, input logic [63:0] t, input bit rdy);
    bit    beat_ok, pop;
    mrec_t r;
    edge_n++;
    beat_ok = !m_done && stop_edge < 0 && wr;
    pop = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (beat_ok && (addr == 21'd1 || addr == 21'd2)) begin
      r.kind = (addr == 21'd2);
      r.id = r.kind ? m_strm : m_ireg;
      r.value = d; r.t0 = t;
      if (r.kind) m_strm = (m_strm + 1) % 256; else m_ireg = (m_ireg + 1) % 256;
      if (m_q.size() < DEPTH) m_q.push_back(r); else m_ovf = 1;
    end
    if (!m_done) begin
      if (simlen != 0 && edge_n == int'(simlen)) begin
        m_done = 1; m_cause = 2;
      end else if (stop_edge >= 0 && edge_n == stop_edge + SD + 1) begin
        m_done = 1; m_cause = 1;
      end else if (beat_ok && addr == 21'd0) begin
        stop_edge = edge_n;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(rec_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("kind",  64'(rec_kind), 64'(m_q[0].kind));
      chk("id",    64'(rec_id),   64'(m_q[0].id));
      chk("value", rec_value,     m_q[0].value);
      chk("taint", rec_value_t0,  m_q[0].t0);
    end
    chk("overflow", 64'(overflow),   64'(m_ovf));
    chk("done",     64'(done),       64'(m_done));
    chk("cause",    64'(done_cause), 64'(m_cause));
  endtask

  task automatic tick(input logic req, input logic we, input logic [20:0] addr,
                      input logic [63:0] d, input logic [63:0] t, input logic rdy);
    mem_req = req; mem_we = we; mem_addr = addr; rec_ready = rdy;
    mem_wdata    = {$urandom, $urandom, d};
    mem_wdata_t0 = {$urandom, $urandom, t};
    @(posedge clk); #1;
    model_edge(req & we, addr, d, t, rdy);
    check_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 21'd0, 64'd0, 64'd0, rdy);
  endtask

  task automatic wr(input logic [20:0] addr, input logic [63:0] d,
                    input logic [63:0] t, input logic rdy);
    tick(1'b1, 1'b1, addr, d, t, rdy);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_kind",  64'(rec_kind),  64'd0);
    chk("rst_id",    64'(rec_id),    64'd0);
    chk("rst_value", rec_value,      64'd0);
    chk("rst_taint", rec_value_t0,   64'd0);
    chk("rst_ovf",   64'(overflow),  64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_cause", 64'(done_cause), 64'd0);
    rst_i = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Three ireg dumps, consumer always ready.
    wr(21'd1, 64'h11, 64'h0, 1'b1);
    wr(21'd1, 64'h22, 64'hF0, 1'b1);
    wr(21'd1, 64'h33, 64'h0, 1'b1);
    idle(2, 1'b1);

    // Interleaved kinds: ids 1, 0, 2.
    do_reset();
    wr(21'd1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    wr(21'd2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    wr(21'd1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    idle(2, 1'b1);

    // Ten beats into a stalled FIFO, then drain and one more beat (id 11).
    do_reset();
    for (int i = 0; i < 10; i++) wr(21'd1, 64'(i + 1), 64'(32'hA0 + i), 1'b0);
    idle(9, 1'b1);
    wr(21'd1, 64'hBEEF, 64'h1, 1'b1);
    idle(2, 1'b1);

    // Stop at edge 10, ireg at edge 11 ignored, done after edge 14.
    do_reset();
    idle(9, 1'b1);
    wr(21'd0, 64'd0, 64'd0, 1'b1);
    wr(21'd1, 64'h55, 64'h0, 1'b1);
    idle(6, 1'b1);

    // simlen=20 without stop, then with stop at edge 20.
    simlen = 32'd20;
    do_reset();
    idle(23, 1'b1);
    do_reset();
    idle(19, 1'b1);
    wr(21'd0, 64'd0, 64'd0, 1'b1);
    idle(3, 1'b1);
    simlen = 32'd0;

    // Reset during drain with two records queued.
    do_reset();
    wr(21'd1, 64'h77, 64'h7, 1'b0);
    wr(21'd2, 64'h88, 64'h8, 1'b0);
    wr(21'd0, 64'd0, 64'd0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    wr(21'd1, 64'h99, 64'h9, 1'b1);
    idle(1, 1'b1);

    // Randomized traffic, random ready and cycle limit.
    for (int it = 0; it < 5; it++) begin
      simlen = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(25, 60));
      do_reset();
      for (int c = 0; c < 80; c++) begin
        int          r;
        logic [20:0] a;
        r = $urandom_range(0, 19);
        a = (r == 0) ? 21'd0 : (r < 9) ? 21'd1 : (r < 15) ? 21'd2 :
            (r < 17) ? 21'd3 : (r < 18) ? 21'h1F0001 : 21'h100002;
        tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), a,
             {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      end
    end
    simlen = 32'd0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
